// File: rtl/arith_tb_pkg.sv
// Shared definitions for the arithmetic test sequencer.
// Contents: FSM state encoding, 64-bit LFSR tap mask, default seed and latency limit,
// and a helper that replaces an all-zero seed with 1.
package arith_tb_pkg;

  // FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Fibonacci feedback taps 64,63,61,60 (bit n maps to index n-1)
  localparam logic [63:0] LFSR_TAPS       = 64'hD800_0000_0000_0000;
  localparam logic [63:0] DEFAULT_SEED    = 64'h0123_4567_89AB_CDEF;
  localparam int unsigned DEFAULT_MAX_LAT = 15;

  // An all-zero LFSR would lock up, so a zero seed becomes 1
  function automatic logic [63:0] fix_seed(input logic [63:0] seed);
    return (seed == 64'd0) ? 64'd1 : seed;
  endfunction

endpackage

// File: rtl/tb_lfsr64.sv
// 64-bit Fibonacci LFSR (taps 64,63,61,60) used as the operand source.
// Ports: clk, reset (async active-low, loads seed), load (sync seed load),
//        adv (step once), hold (freeze state; load still wins), state (current value).
module tb_lfsr64
  import arith_tb_pkg::*;
#(
  parameter logic [63:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        adv,
  input  logic        hold,
  output logic [63:0] state
);

  localparam logic [63:0] SEED_EFF = fix_seed(SEED);

  logic [63:0] lfsr_q;
  logic [63:0] lfsr_d;

  // Next-state: load > hold > advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED_EFF;
    end else if (!hold && adv) begin
      lfsr_d = {lfsr_q[62:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/arith_test_sequencer.sv
// Drives pseudo-random operand pairs into an external adder, waits a programmable
// latency, compares its result against a locally computed sum and counts samples
// and mismatches (both saturating).
// Ports: clk, reset (async active-low); enable/freeze/clear host controls
//        (priority clear > freeze > enable); cfg_latency, cfg_count configuration;
//        dut_a/dut_b operands out, dut_s result in; o_data_ctr, o_event_ctr counters;
//        o_busy, o_done status; o_debug = {state, zeros, latency counter}.
// Optional: define ERR_CAPTURE_EN to add o_err_a/o_err_b/o_err_s/o_err_valid,
//           which capture the first mismatching sample since reset or clear.
module arith_test_sequencer
  import arith_tb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter logic [63:0] SEED    = DEFAULT_SEED,
  parameter int unsigned MAX_LAT = DEFAULT_MAX_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  input  logic             clear,
  input  logic [3:0]       cfg_latency,
  input  logic [WIDTH-1:0] cfg_count,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_s,
  output logic [WIDTH-1:0] o_data_ctr,
  output logic [WIDTH-1:0] o_event_ctr,
  output logic             o_busy,
  output logic             o_done,
`ifdef ERR_CAPTURE_EN
  output logic [WIDTH-1:0] o_err_a,
  output logic [WIDTH-1:0] o_err_b,
  output logic [WIDTH-1:0] o_err_s,
  output logic             o_err_valid,
`endif
  output logic [WIDTH-1:0] o_debug
);

  localparam logic [3:0] LAT_LIM = (MAX_LAT > 15) ? 4'd15 : 4'(MAX_LAT);

  state_e           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d, event_q, event_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             mism;
  logic             lfsr_adv;
  logic [63:0]      lfsr;
  logic [3:0]       lat_cfg;
  logic [WIDTH+2:0] dbg_state;

  tb_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (clear),
    .adv   (lfsr_adv),
    .hold  (freeze),
    .state (lfsr)
  );

  assign lat_cfg = (cfg_latency > LAT_LIM) ? LAT_LIM : cfg_latency;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    samp_d   = samp_q;
    exp_d    = exp_q;
    a_d      = a_q;
    b_d      = b_q;
    data_d   = data_q;
    event_d  = event_q;
    mism     = 1'b0;
    lfsr_adv = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      lat_d   = '0;
      samp_d  = '0;
      exp_d   = '0;
      a_d     = '0;
      b_d     = '0;
      data_d  = '0;
      event_d = '0;
    end else if (!freeze) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_d = ST_DRIVE;
            samp_d  = '0;
          end
        end
        ST_DRIVE: begin
          a_d      = lfsr[WIDTH-1:0];
          b_d      = lfsr[32+WIDTH-1:32];
          exp_d    = lfsr[WIDTH-1:0] + lfsr[32+WIDTH-1:32];
          lat_d    = lat_cfg;
          lfsr_adv = 1'b1;
          state_d  = (lat_cfg == 4'd0) ? ST_CHECK : ST_WAIT;
        end
        ST_WAIT: begin
          lat_d = lat_q - 4'd1;
          if (lat_q <= 4'd1) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          mism   = (dut_s != exp_q);
          samp_d = samp_q + WIDTH'(1);
          if (data_q != '1) begin
            data_d = data_q + WIDTH'(1);
          end
          if (mism && (event_q != '1)) begin
            event_d = event_q + WIDTH'(1);
          end
          // Burst end uses the post-increment sample count
          if ((cfg_count != '0) && (samp_d == cfg_count)) begin
            state_d = ST_DONE;
          end else if (!enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      samp_q  <= '0;
      exp_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      event_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      samp_q  <= samp_d;
      exp_q   <= exp_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      event_q <= event_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ERR_CAPTURE_EN
  logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d, err_s_q, err_s_d;
  logic             err_valid_q, err_valid_d;

  // Capture only the first mismatch since reset or clear
  always_comb begin
    err_a_d     = err_a_q;
    err_b_d     = err_b_q;
    err_s_d     = err_s_q;
    err_valid_d = err_valid_q;
    if (clear) begin
      err_a_d     = '0;
      err_b_d     = '0;
      err_s_d     = '0;
      err_valid_d = 1'b0;
    end else if (mism && !err_valid_q) begin
      err_a_d     = a_q;
      err_b_d     = b_q;
      err_s_d     = dut_s;
      err_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_a_q     <= '0;
      err_b_q     <= '0;
      err_s_q     <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      err_s_q     <= err_s_d;
      err_valid_q <= err_valid_d;
    end
  end

  assign o_err_a     = err_a_q;
  assign o_err_b     = err_b_q;
  assign o_err_s     = err_s_q;
  assign o_err_valid = err_valid_q;
`endif

  // State lands in the top three bits, latency counter in the low nibble
  assign dbg_state   = {state_q, WIDTH'(0)};
  assign o_debug     = dbg_state[WIDTH+2:3] | WIDTH'(lat_q);
  assign dut_a       = a_q;
  assign dut_b       = b_q;
  assign o_data_ctr  = data_q;
  assign o_event_ctr = event_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_arith_test_sequencer.sv
// Self-checking bench for arith_test_sequencer (WIDTH=8, MAX_LAT=12).
// The external adder is modelled as a delay line whose output may carry an
// injected error; a reference model tracks the LFSR sequence and counters.
module tb_arith_test_sequencer;

  localparam int unsigned W    = 8;
  localparam int          MAXL = 12;
  localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

  logic         clk = 1'b0;
  logic         reset, enable, freeze, clear;
  logic [3:0]   cfg_latency;
  logic [W-1:0] cfg_count, dut_a, dut_b, dut_s;
  logic [W-1:0] o_data_ctr, o_event_ctr, o_debug;
  logic         o_busy, o_done;

  int errors = 0;
  int checks = 0;
  int dut_lat = 0;
  int dut_mode = 0;
  logic [W-1:0] pipe [16];

  logic [63:0] m_lfsr;
  int          m_data, m_event;

  arith_test_sequencer #(.WIDTH(W), .SEED(SEED), .MAX_LAT(MAXL)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .freeze      (freeze),
    .clear       (clear),
    .cfg_latency (cfg_latency),
    .cfg_count   (cfg_count),
    .dut_a       (dut_a),
    .dut_b       (dut_b),
    .dut_s       (dut_s),
    .o_data_ctr  (o_data_ctr),
    .o_event_ctr (o_event_ctr),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_debug     (o_debug)
  );

  always #5 clk = ~clk;

  // mode 0: correct adder, 1: always off by one, 2: off by one on some operand pairs
  function automatic logic inj_err(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    if (mode == 1) return 1'b1;
    if (mode == 2) return a[0] ^ b[1];
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] adder(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    return a + b + W'(inj_err(mode, a, b));
  endfunction

  always @(posedge clk) begin
    pipe[0] <= adder(dut_mode, dut_a, dut_b);
    for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
  end

  always_comb begin
    if (dut_lat == 0) dut_s = adder(dut_mode, dut_a, dut_b);
    else              dut_s = pipe[dut_lat-1];
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    int   taps [4] = '{64, 63, 61, 60};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]-1];
    return {s[62:0], fb};
  endfunction

  // Reference: one completed sample
  task automatic m_step(input int mode);
    logic [W-1:0] a, b;
    a = m_lfsr[W-1:0];
    b = m_lfsr[32+W-1:32];
    m_lfsr = lfsr_next(m_lfsr);
    if (m_data < 255) m_data++;
    if (inj_err(mode, a, b) && m_event < 255) m_event++;
  endtask

  task automatic m_reset();
    m_lfsr  = SEED;
    m_data  = 0;
    m_event = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_reset();
    chk("clear_data", int'(o_data_ctr), 0);
    chk("clear_busy", int'(o_busy), 0);
  endtask

  task automatic finish_burst();
    tick();
    tick();
    chk("done_hold", int'(o_done), 1);
    enable = 1'b0;
    tick();
    chk("done_drop", int'(o_done), 0);
    chk("idle_after_done", int'(o_debug[7:5]), 0);
  endtask

  task automatic run_burst(input int cl, input int dl, input int cnt, input int mode, output int cyc);
    cfg_latency = 4'(cl);
    dut_lat     = dl;
    dut_mode    = mode;
    cfg_count   = W'(cnt);
    enable      = 1'b1;
    cyc         = 0;
    while (cyc < 20000 && !o_done) begin
      tick();
      cyc++;
    end
    for (int k = 0; k < cnt; k++) m_step(mode);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 200 && o_busy) begin
      tick();
      n++;
    end
    chk(name, int'(o_busy), 0);
  endtask

  typedef struct {
    int cl; int dl; int cnt; int mode; int cyc; int data; int evt;
  } vec_t;

  initial begin
    vec_t        vt [5];
    int          cyc;
    logic [41:0] snap;
    int          wrapped, prev_d, prev_e;

    vt[0] = '{3, 3, 100, 0, 501, 100, 0};
    vt[1] = '{0, 0, 16, 1, 33, 16, 16};
    vt[2] = '{15, 12, 4, 0, 57, 4, 0};
    vt[3] = '{1, 1, 3, 1, 10, 3, 3};
    vt[4] = '{12, 12, 2, 1, 29, 2, 2};

    reset = 1'b0; enable = 1'b0; freeze = 1'b0; clear = 1'b0;
    cfg_latency = 4'd0; cfg_count = '0;
    m_reset();
    tick();
    tick();
    chk("rst_dut_a", int'(dut_a), 0);
    chk("rst_dut_b", int'(dut_b), 0);
    chk("rst_data", int'(o_data_ctr), 0);
    chk("rst_event", int'(o_event_ctr), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_debug", int'(o_debug), 0);
    reset = 1'b1;
    tick();

    // Table-driven bursts with fixed error patterns
    foreach (vt[i]) begin
      do_clear();
      run_burst(vt[i].cl, vt[i].dl, vt[i].cnt, vt[i].mode, cyc);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d_data", i), int'(o_data_ctr), vt[i].data);
      chk($sformatf("vec%0d_event", i), int'(o_event_ctr), vt[i].evt);
      finish_burst();
    end

    // Freeze for 10 cycles during WAIT of sample 5
    do_clear();
    cfg_latency = 4'd3; dut_lat = 3; dut_mode = 2; cfg_count = W'(10);
    enable = 1'b1;
    cyc = 0;
    repeat (23) begin tick(); cyc++; end
    chk("frz_in_wait", int'(o_debug), 8'h42);
    chk("frz_busy", int'(o_busy), 1);
    snap = {dut_a, dut_b, o_data_ctr, o_event_ctr, o_debug, o_busy, o_done};
    freeze = 1'b1;
    repeat (10) begin
      tick();
      cyc++;
      chk("frz_hold", int'({dut_a, dut_b, o_data_ctr, o_event_ctr, o_debug, o_busy, o_done} == snap), 1);
    end
    freeze = 1'b0;
    while (cyc < 2000 && !o_done) begin tick(); cyc++; end
    for (int k = 0; k < 10; k++) m_step(2);
    chk("frz_cycles", cyc, 61);
    chk("frz_data", int'(o_data_ctr), m_data);
    chk("frz_event", int'(o_event_ctr), m_event);
    finish_burst();

    // Enable dropped during WAIT of sample 7
    do_clear();
    cfg_latency = 4'd4; dut_lat = 4; dut_mode = 2; cfg_count = '0;
    enable = 1'b1;
    repeat (39) tick();
    chk("drop_in_wait", int'(o_debug), 8'h43);
    enable = 1'b0;
    wait_idle("drop_to_idle");
    for (int k = 0; k < 7; k++) m_step(2);
    chk("drop_data", int'(o_data_ctr), 7);
    chk("drop_event", int'(o_event_ctr), m_event);
    chk("drop_done", int'(o_done), 0);
    chk("drop_state", int'(o_debug[7:5]), 0);

    // Asynchronous reset in the middle of WAIT
    cfg_latency = 4'd5; dut_lat = 5; dut_mode = 0; cfg_count = '0;
    enable = 1'b1;
    repeat (3) tick();
    #3;
    reset = 1'b0;
    #1;
    chk("arst_dut_a", int'(dut_a), 0);
    chk("arst_dut_b", int'(dut_b), 0);
    chk("arst_data", int'(o_data_ctr), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_debug", int'(o_debug), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_reset();
    tick();
    tick();
    chk("arst_first_a", int'(dut_a), int'(SEED[7:0]));
    chk("arst_first_b", int'(dut_b), int'(SEED[39:32]));
    enable = 1'b0;
    wait_idle("arst_idle");
    m_step(0);
    chk("arst_data_after", int'(o_data_ctr), m_data);
    chk("arst_event_after", int'(o_event_ctr), 0);

    // Saturation: free-running, every sample wrong
    do_clear();
    cfg_latency = 4'd0; dut_lat = 0; dut_mode = 1; cfg_count = '0;
    enable = 1'b1;
    wrapped = 0; prev_d = 0; prev_e = 0;
    repeat (600) begin
      tick();
      if (int'(o_data_ctr) < prev_d || int'(o_event_ctr) < prev_e) wrapped = 1;
      prev_d = int'(o_data_ctr);
      prev_e = int'(o_event_ctr);
    end
    enable = 1'b0;
    wait_idle("sat_idle");
    chk("sat_no_wrap", wrapped, 0);
    chk("sat_data", int'(o_data_ctr), 255);
    chk("sat_event", int'(o_event_ctr), 255);

    // Randomised bursts; counters and LFSR carry over between bursts
    do_clear();
    for (int r = 0; r < 6; r++) begin
      int cl, dl, cnt, mode;
      cl   = int'($urandom_range(0, 15));
      dl   = (cl > MAXL) ? MAXL : cl;
      cnt  = int'($urandom_range(1, 20));
      mode = int'($urandom_range(0, 2));
      run_burst(cl, dl, cnt, mode, cyc);
      chk($sformatf("rnd%0d_cycles", r), cyc, 1 + cnt * (dl + 2));
      chk($sformatf("rnd%0d_data", r), int'(o_data_ctr), m_data);
      chk($sformatf("rnd%0d_event", r), int'(o_event_ctr), m_event);
      finish_burst();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
